// File: rtl/atpg_response_checker.sv
// rtl/atpg_response_checker.sv - capture-side ATPG response checker with mismatch count and 8-bit MISR
module atpg_response_checker #(
    parameter int NUM_PAT = 4,
    parameter int SETTLE  = 2,
    localparam int IDXW   = $clog2(NUM_PAT),
    localparam int CNTW   = $clog2(NUM_PAT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_PAT-1:0] expected,
    input  logic               pat_valid,
    output logic               pat_ready,
    input  logic               y,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [CNTW-1:0]    mismatch_cnt,
    output logic [IDXW-1:0]    first_fail_idx,
    output logic [7:0]         signature
);

    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_PAT-1:0] expected_q;
    logic [IDXW-1:0]    idx;
    logic [SW-1:0]      settle_cnt;
    logic               start_ok;
    logic               last_pat;
    logic               miss;
    logic [7:0]         sig_nxt;

    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_pat = (idx == IDXW'(NUM_PAT - 1));
    assign miss     = (y != expected_q[idx]);
    assign sig_nxt  = {signature[6:0], 1'b0} ^ (signature[7] ? 8'h1D : 8'h00) ^ {7'b0, y};

    assign pat_ready = (state == S_WAIT);
    assign busy      = (state == S_WAIT) || (state == S_SETTLE) || (state == S_SAMPLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pat_valid) begin
                    state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                end
            end
            // Counter was loaded with SETTLE, so leaving on 1 spends exactly SETTLE cycles here.
            S_SETTLE: begin
                if (settle_cnt == SW'(1)) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                state_nxt = last_pat ? S_DONE : S_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected_q     <= '0;
            idx            <= '0;
            settle_cnt     <= '0;
            fail           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            signature      <= 8'h00;
        end else if (start_ok) begin
            expected_q     <= expected;
            idx            <= '0;
            fail           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            signature      <= 8'h00;
        end else begin
            case (state)
                S_WAIT: begin
                    if (pat_valid) begin
                        settle_cnt <= SW'(SETTLE);
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - SW'(1);
                end
                S_SAMPLE: begin
                    if (miss) begin
                        mismatch_cnt <= mismatch_cnt + CNTW'(1);
                        if (!fail) begin
                            fail           <= 1'b1;
                            first_fail_idx <= idx;
                        end
                    end
                    signature <= sig_nxt;
                    if (!last_pat) begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_atpg_response_checker.sv
// tb/tb_atpg_response_checker.sv - scoreboard bench for atpg_response_checker (SETTLE=2 and SETTLE=0 builds)
module tb_atpg_response_checker;

    typedef struct {
        int fail;
        int cnt;
        int ffi;
        int sig;
    } result_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_v;
    logic [1:0] pv_v;
    logic [1:0] y_v;
    logic [3:0] exp_v [2];
    logic [1:0] pr_v;
    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [1:0] fail_v;
    logic [2:0] cnt_v [2];
    logic [1:0] ffi_v [2];
    logic [7:0] sig_v [2];
    logic [1:0] done_q;

    int n_checks = 0;
    int n_err    = 0;
    result_t q_a[$];
    result_t q_b[$];

    atpg_response_checker #(.NUM_PAT(4), .SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .expected(exp_v[0]),
        .pat_valid(pv_v[0]), .pat_ready(pr_v[0]), .y(y_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .fail(fail_v[0]), .mismatch_cnt(cnt_v[0]),
        .first_fail_idx(ffi_v[0]), .signature(sig_v[0])
    );

    atpg_response_checker #(.NUM_PAT(4), .SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .expected(exp_v[1]),
        .pat_valid(pv_v[1]), .pat_ready(pr_v[1]), .y(y_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .fail(fail_v[1]), .mismatch_cnt(cnt_v[1]),
        .first_fail_idx(ffi_v[1]), .signature(sig_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: compare each bit, count misses, and clock a GF(2) x^8+x^4+x^3+x^2+1 divider.
    function automatic result_t model(input logic [3:0] e, input logic [3:0] ys);
        result_t r;
        int s;
        r.fail = 0; r.cnt = 0; r.ffi = 0; s = 0;
        for (int i = 0; i < 4; i++) begin
            if (ys[i] != e[i]) begin
                r.cnt++;
                if (r.fail == 0) begin
                    r.fail = 1;
                    r.ffi  = i;
                end
            end
            s = s * 2;
            if (s > 255) s = s ^ 'h11D;
            s = s ^ int'(ys[i]);
        end
        r.sig = s;
        return r;
    endfunction

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (done_v[s] && !done_q[s]) begin
                result_t r;
                if ((s == 0 && q_a.size() == 0) || (s == 1 && q_b.size() == 0)) begin
                    chk("sb_unexpected_done", s, -1);
                end else begin
                    r = (s == 0) ? q_a.pop_front() : q_b.pop_front();
                    chk($sformatf("sb%0d_fail", s), int'(fail_v[s]), r.fail);
                    chk($sformatf("sb%0d_cnt", s), int'(cnt_v[s]), r.cnt);
                    chk($sformatf("sb%0d_ffi", s), int'(ffi_v[s]), r.ffi);
                    chk($sformatf("sb%0d_sig", s), int'(sig_v[s]), r.sig);
                end
            end
        end
        done_q <= done_v;
    end

    task automatic drive_pat(input int sel, input logic yv, input bit noise, input bit hold);
        int n = 0;
        int settle = (sel == 0) ? 2 : 0;
        while (!pr_v[sel] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!pr_v[sel]) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        pv_v[sel] = 1'b1;
        y_v[sel]  = noise ? ~yv : yv;
        @(posedge clk);
        for (int i = 0; i < settle; i++) begin
            @(negedge clk);
            pv_v[sel] = hold;
            y_v[sel]  = noise ? ~yv : yv;
            chk("settle_ready_low", int'(pr_v[sel]), 0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("sample_busy", int'(busy_v[sel]), 1);
        pv_v[sel] = 1'b0;
        y_v[sel]  = yv;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_run(input int sel, input logic [3:0] e, input logic [3:0] ys, input bit push);
        if (push) begin
            if (sel == 0) q_a.push_back(model(e, ys));
            else          q_b.push_back(model(e, ys));
        end
        @(negedge clk);
        start_v[sel] = 1'b1;
        exp_v[sel]   = e;
        @(posedge clk);
        @(negedge clk);
        start_v[sel] = 1'b0;
        exp_v[sel]   = 4'($urandom);
        chk("start_ready", int'(pr_v[sel]), 1);
        chk("start_done", int'(done_v[sel]), 0);
        chk("start_cnt", int'(cnt_v[sel]), 0);
        chk("start_sig", int'(sig_v[sel]), 0);
        chk("start_fail", int'(fail_v[sel]), 0);
    endtask

    task automatic run(input int sel, input logic [3:0] e, input logic [3:0] ys,
                       input int start_at, input bit noise, input bit hold);
        start_run(sel, e, ys, 1'b1);
        for (int p = 0; p < 4; p++) begin
            if (p == start_at) begin
                start_v[sel] = 1'b1;
                exp_v[sel]   = ~e;
                @(posedge clk);
                @(negedge clk);
                start_v[sel] = 1'b0;
                chk("ign_start_ready", int'(pr_v[sel]), 1);
                chk("ign_start_busy", int'(busy_v[sel]), 1);
            end
            drive_pat(sel, ys[p], noise, hold);
            if (p < 3) begin
                chk("ready_again", int'(pr_v[sel]), 1);
            end else begin
                chk("end_done", int'(done_v[sel]), 1);
                chk("end_busy", int'(busy_v[sel]), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_v = '0; pv_v = '0; y_v = '0; done_q = '0;
        exp_v[0] = '0; exp_v[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy_v[0]), 0);
        chk("rst_ready", int'(pr_v[0]), 0);
        chk("rst_done", int'(done_v[0]), 0);
        chk("rst_fail", int'(fail_v[0]), 0);
        chk("rst_cnt", int'(cnt_v[0]), 0);
        chk("rst_ffi", int'(ffi_v[0]), 0);
        chk("rst_sig", int'(sig_v[0]), 0);
        chk("rst_sig_b", int'(sig_v[1]), 0);
        rst_n = 1'b1;

        run(0, 4'b1010, 4'b1010, -1, 1'b0, 1'b0);
        chk("clean_sig", int'(sig_v[0]), 'h05);
        chk("clean_fail", int'(fail_v[0]), 0);

        run(0, 4'b1010, 4'b1011, -1, 1'b0, 1'b0);
        chk("fault_sig", int'(sig_v[0]), 'h0D);
        chk("fault_cnt", int'(cnt_v[0]), 1);
        chk("fault_ffi", int'(ffi_v[0]), 0);

        run(0, 4'b1010, 4'b1010, -1, 1'b1, 1'b1);
        chk("settle_noise_cnt", int'(cnt_v[0]), 0);

        run(0, 4'b1010, 4'b1011, 2, 1'b0, 1'b0);
        chk("ign_start_cnt", int'(cnt_v[0]), 1);

        start_run(0, 4'b1010, 4'b1011, 1'b0);
        drive_pat(0, 1'b1, 1'b0, 1'b0);
        drive_pat(0, 1'b1, 1'b0, 1'b0);
        pv_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pv_v[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy_v[0]), 0);
        chk("arst_fail", int'(fail_v[0]), 0);
        chk("arst_cnt", int'(cnt_v[0]), 0);
        chk("arst_sig", int'(sig_v[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 4'b1010, 4'b1010, -1, 1'b0, 1'b0);
        chk("post_rst_sig", int'(sig_v[0]), 'h05);

        run(1, 4'b0101, 4'b1010, -1, 1'b0, 1'b0);
        chk("s0_cnt", int'(cnt_v[1]), 4);
        chk("s0_ffi", int'(ffi_v[1]), 0);

        for (int k = 0; k < 12; k++) begin
            run(k % 2, 4'($urandom), 4'($urandom), int'($urandom_range(0, 4)),
                1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("sb_a_drained", q_a.size(), 0);
        chk("sb_b_drained", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/atpg_response_checker.md
# atpg_response_checker

Synthesizable capture-side checker for two-vector (launch/capture) ATPG runs on `injection_module`. A pattern applier drives each vector pair into the DUT. This block accepts one capture strobe per pattern, waits a settle window, and samples `y`. It compares each sample against a golden bit, counts mismatches, records the first failing pattern and compacts all responses into an 8-bit MISR signature. It replaces file-based response dumping when the fault-injection flow runs in emulation or on silicon.

## Interface
Parameters:
- `NUM_PAT`, 4: patterns per run, ≥2.
- `SETTLE`, 2: idle cycles between accepting a capture strobe and sampling `y`, ≥0.

Derived widths: `IDXW = $clog2(NUM_PAT)`, `CNTW = $clog2(NUM_PAT+1)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle run request. Honoured only in IDLE or DONE.
- `expected` in NUM_PAT: golden response. Bit i is the expected `y` for pattern i. Latched at accepted `start`.
- `pat_valid` in 1: applier signals that the capture vector is on the DUT inputs.
- `pat_ready` out 1: checker can accept a capture strobe.
- `y` in 1: DUT response.
- `busy` out 1: run in progress.
- `done` out 1: run complete. Held until the next accepted `start`.
- `fail` out 1: at least one mismatch in the current/last run.
- `mismatch_cnt` out CNTW: number of mismatching patterns.
- `first_fail_idx` out IDXW: index of the first mismatching pattern. Valid when `fail`=1.
- `signature` out 8: MISR over sampled `y`.

## Operation
- FSM states: IDLE, WAIT, SETTLE, SAMPLE, DONE.
- IDLE/DONE, `start`=1:
  - latch `expected`
  - clear `mismatch_cnt`, `fail`, `first_fail_idx`
  - `signature`=8'h00, `idx`=0, `done`=0
  - go to WAIT.
- WAIT: `pat_ready`=1. On `pat_valid`&&`pat_ready`, load `settle_cnt`=SETTLE. Go to SETTLE, or to SAMPLE directly when SETTLE=0.
- SETTLE: decrement `settle_cnt` each cycle. Leave for SAMPLE in the cycle it reaches 0, so exactly SETTLE cycles are spent here. `y` is ignored.
- SAMPLE, one cycle:
  - On `y`≠`expected_q[idx]`, increment `mismatch_cnt`. If `fail`=0, set `first_fail_idx`=`idx` and `fail`=1.
  - Update the MISR: fb=sig[7]; sig ← {sig[6:0],1'b0} ^ (fb ? 8'h1D : 8'h00) ^ {7'b0,y}.
  - If `idx`=NUM_PAT-1, go to DONE. Otherwise `idx`++ and return to WAIT.
- DONE: `done`=1. Results are frozen until `start`.
- `start` in WAIT, SETTLE or SAMPLE is ignored. Runs cannot be aborted except by reset.
- `pat_valid` outside WAIT is ignored and not queued.
- `busy`=1 in WAIT, SETTLE and SAMPLE.
- `mismatch_cnt` cannot overflow because CNTW covers NUM_PAT.

## Timing
- Reset (async assert, sync deassert in the host): state=IDLE. All outputs are 0, including `signature`=8'h00 and `first_fail_idx`=0.
- All outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.
- Strobe accepted at edge k → `y` sampled at edge k+SETTLE+1.
- Results are visible after edge k+SETTLE+1. `pat_ready` reasserts the cycle after that edge, unless it was the last pattern.
- Last SAMPLE edge → `done`=1 and `busy`=0 from the same edge.
- `start` in DONE: `done` drops and `pat_ready` rises on the next edge.
- Reset asserted mid-run returns to IDLE immediately and discards partial results.

## Test plan
- Clean run (NUM_PAT=4, SETTLE=2, `expected`=4'b1010), `y`=0,1,0,1 for patterns 0..3 → `done`=1, `fail`=0, `mismatch_cnt`=0, `signature`=8'h05.
- Single fault, same `expected`, `y`=1,1,0,1 → `fail`=1, `mismatch_cnt`=1, `first_fail_idx`=0, `signature`=8'h0D (intermediate values 01,03,06,0D).
- Settle window: `y` held wrong for 2 cycles after acceptance, correct on the sample cycle → counted as a pass. `pat_valid` held high throughout SETTLE → exactly one pattern consumed.
- Ignored `start`: `start` pulsed while in WAIT after pattern 1 → `idx` and counters unchanged, and the run completes normally. `start` in DONE → all results cleared and `pat_ready`=1 next cycle.
- Reset mid-run: `rst_n` pulled low during SETTLE of pattern 2 → all outputs 0 asynchronously. A new `start` then a full clean run → `signature`=8'h05.
- SETTLE=0 build: `y` sampled the edge after acceptance, and all four mismatches (`y`=0,1,0,1 vs `expected`=4'b0101) → `mismatch_cnt`=4, `first_fail_idx`=0.
